// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants and types for the seven-segment scan multiplexer.
package seg7_scan_mux_pkg;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [31:0] AN_OFF    = '1;

  typedef enum logic {
    SLOT_BLANK,
    SLOT_DRIVE
  } slot_state_e;

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot/digit timebase: owns the slot counter and digit index, decodes the
// BLANK/DRIVE phase and produces the frame-boundary strobe and frame_start.
module seg7_scan_timer
  import seg7_scan_mux_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 100000,
  parameter int BLANK  = 16,
  parameter int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output slot_state_e      slot_state,
  output logic             frame_end,
  output logic             frame_start
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             en_q;
  logic             cnt_last;
  logic             idx_last;

  assign cnt_last   = (cnt == CNT_W'(DIV - 1));
  assign idx_last   = (idx == IDX_W'(DIGITS - 1));
  assign frame_end  = en && cnt_last && idx_last;
  assign slot_state = (int'(cnt) < BLANK) ? SLOT_BLANK : SLOT_DRIVE;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      en_q        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      en_q <= en;
      // A new frame begins at a natural boundary, or on the first enabled
      // cycle after a disabled period (reset exit counts as one).
      frame_start <= frame_end || (en && !en_q);
      if (!en) begin
        cnt <= '0;
        idx <= '0;
      end else if (cnt_last) begin
        cnt <= '0;
        idx <= idx_last ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit common-anode scan multiplexer with anti-ghost blanking and
// frame-synchronous data commit. Optional macro SEG7_BRIGHTNESS_EN adds a
// 4-bit brightness input that PWM-gates the anode during DRIVE.
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 100000,
  parameter int BLANK  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7*DIGITS-1:0] seg_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load,
  input  logic                en,
`ifdef SEG7_BRIGHTNESS_EN
  input  logic [3:0]          brightness,
`endif
  output logic [6:0]          seg_out,
  output logic                dp_out,
  output logic [DIGITS-1:0]   an_out,
  output logic                frame_start,
  output logic                pending
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [IDX_W-1:0]    idx;
  slot_state_e         slot_state;
  logic                frame_end;
  logic                commit_point;
  logic                drive;
  logic [7*DIGITS-1:0] stage_seg;
  logic [7*DIGITS-1:0] shadow_seg;
  logic [DIGITS-1:0]   stage_dp;
  logic [DIGITS-1:0]   shadow_dp;

  seg7_scan_timer #(
    .DIGITS (DIGITS),
    .DIV    (DIV),
    .BLANK  (BLANK),
    .IDX_W  (IDX_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .idx         (idx),
    .slot_state  (slot_state),
    .frame_end   (frame_end),
    .frame_start (frame_start)
  );

  // While disabled every cycle is a commit point, so staged data is ready
  // on re-enable.
  assign commit_point = frame_end || !en;

  // NOTE: staging and shadow registers are reset (not left as uninitialised
  // storage) because their reset contents are visible on the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_seg  <= {DIGITS{SEG_BLANK}};
      shadow_seg <= {DIGITS{SEG_BLANK}};
      stage_dp   <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        stage_seg <= seg_in;
        stage_dp  <= dp_in;
      end
      if (load && frame_end) begin
        shadow_seg <= seg_in;
        shadow_dp  <= dp_in;
        pending    <= 1'b0;
      end else begin
        if (commit_point && pending) begin
          shadow_seg <= stage_seg;
          shadow_dp  <= stage_dp;
        end
        if (load) begin
          pending <= 1'b1;
        end else if (commit_point) begin
          pending <= 1'b0;
        end
      end
    end
  end

`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0] duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= 4'd0;
    end else begin
      duty <= duty + 4'd1;
    end
  end

  assign drive = en && (slot_state == SLOT_DRIVE) && (duty < brightness);
`else
  assign drive = en && (slot_state == SLOT_DRIVE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_out  <= AN_OFF[DIGITS-1:0];
      seg_out <= SEG_BLANK;
      dp_out  <= 1'b1;
    end else if (drive) begin
      an_out  <= ~(DIGITS'(1) << idx);
      seg_out <= shadow_seg[7*idx +: 7];
      dp_out  <= ~shadow_dp[idx];
    end else begin
      an_out  <= AN_OFF[DIGITS-1:0];
      seg_out <= SEG_BLANK;
      dp_out  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (DIGITS=4, DIV=8, BLANK=2): directed
// scenarios plus random traffic against a time-based reference model.
module tb_seg7_scan_mux;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7*DIGITS-1:0] seg_in;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                en;
  logic [6:0]          seg_out;
  logic                dp_out;
  logic [DIGITS-1:0]   an_out;
  logic                frame_start;
  logic                pending;

  seg7_scan_mux #(
    .DIGITS (DIGITS),
    .DIV    (DIV),
    .BLANK  (BLANK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dp_in       (dp_in),
    .load        (load),
    .en          (en),
    .seg_out     (seg_out),
    .dp_out      (dp_out),
    .an_out      (an_out),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: t is the number of enabled cycles since the current
  // scan origin; digit and slot phase follow from plain division.
  logic [6:0]        m_shadow_seg [DIGITS];
  logic              m_shadow_dp  [DIGITS];
  logic [6:0]        m_stage_seg  [DIGITS];
  logic              m_stage_dp   [DIGITS];
  logic              m_pend;
  logic              m_en_prev;
  int                t;
  logic [DIGITS-1:0] e_an;
  logic [6:0]        e_seg;
  logic              e_dp;
  logic              e_fs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < DIGITS; k++) begin
      m_shadow_seg[k] = 7'h7F;
      m_shadow_dp[k]  = 1'b0;
      m_stage_seg[k]  = 7'h7F;
      m_stage_dp[k]   = 1'b0;
    end
    m_pend    = 1'b0;
    m_en_prev = 1'b0;
    t         = 0;
  endtask

  task automatic model_edge();
    int  pos;
    int  dig;
    bit  last;
    bit  commit;
    pos    = t % DIV;
    dig    = (t / DIV) % DIGITS;
    last   = en && ((t % FRAME) == FRAME - 1);
    commit = last || !en;
    if (!en || pos < BLANK) begin
      e_an  = '1;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an      = '1;
      e_an[dig] = 1'b0;
      e_seg     = m_shadow_seg[dig];
      e_dp      = ~m_shadow_dp[dig];
    end
    e_fs = en && (last || !m_en_prev);
    if (load && last) begin
      for (int k = 0; k < DIGITS; k++) begin
        m_shadow_seg[k] = seg_in[7*k +: 7];
        m_shadow_dp[k]  = dp_in[k];
        m_stage_seg[k]  = seg_in[7*k +: 7];
        m_stage_dp[k]   = dp_in[k];
      end
      m_pend = 1'b0;
    end else begin
      if (commit && m_pend) begin
        m_shadow_seg = m_stage_seg;
        m_shadow_dp  = m_stage_dp;
      end
      if (load) begin
        for (int k = 0; k < DIGITS; k++) begin
          m_stage_seg[k] = seg_in[7*k +: 7];
          m_stage_dp[k]  = dp_in[k];
        end
        m_pend = 1'b1;
      end else if (commit) begin
        m_pend = 1'b0;
      end
    end
    m_en_prev = en;
    t = en ? t + 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("an_out", an_out, e_an);
    check("seg_out", seg_out, e_seg);
    check("dp_out", dp_out, e_dp);
    check("frame_start", frame_start, e_fs);
    check("pending", pending, m_pend);
  endtask

  // Advance until the next edge will see scan position pos within the frame.
  task automatic run_to(input int pos);
    for (int i = 0; i <= FRAME && (t % FRAME) != pos; i++) tick();
  endtask

  task automatic pulse_load(input logic [7*DIGITS-1:0] s, input logic [DIGITS-1:0] d);
    seg_in = s;
    dp_in  = d;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  initial begin
    int                  fs_count;
    logic [7*DIGITS-1:0] data;

    load   = 1'b0;
    en     = 1'b1;
    seg_in = '1;
    dp_in  = '0;
    model_reset();

    // Reset held with clock running.
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", an_out, 4'hF);
    check("rst_seg", seg_out, 7'h7F);
    check("rst_dp", dp_out, 1'b1);
    check("rst_pending", pending, 1'b0);
    check("rst_fs", frame_start, 1'b0);
    rst_n = 1'b1;

    // Basic load: committed at the first frame boundary.
    pulse_load({7'h30, 7'h24, 7'h79, 7'h40}, 4'b0100);
    check("basic_pending", pending, 1'b1);
    fs_count = 0;
    repeat (3 * FRAME) begin
      tick();
      if (frame_start) fs_count++;
    end
    check("basic_fs_count", fs_count, 3);
    run_to(3);
    check("basic_dig0_an", an_out, 4'hE);
    check("basic_dig0_seg", seg_out, 7'h40);
    run_to(2 * DIV + 3);
    check("basic_dig2_an", an_out, 4'hB);
    check("basic_dig2_dp", dp_out, 1'b0);

    // Mid-frame load during the digit-2 slot.
    run_to(2 * DIV + 1);
    pulse_load(28'($urandom), 4'($urandom));
    check("mid_pending", pending, 1'b1);
    run_to(0);
    check("mid_pending_clear", pending, 1'b0);
    run_to(DIV + 4);

    // Load coinciding with the frame boundary bypasses staging.
    run_to(FRAME - 1);
    data = 28'($urandom);
    pulse_load(data, 4'($urandom));
    check("coinc_pending", pending, 1'b0);
    run_to(3);
    check("coinc_dig0_seg", seg_out, data[6:0]);
    check("coinc_pending_stays", pending, 1'b0);

    // Enable gap during digit-1 DRIVE, with a load while disabled.
    run_to(DIV + 4);
    en = 1'b0;
    tick();
    check("gap_blank_an", an_out, 4'hF);
    pulse_load(28'($urandom), 4'($urandom));
    repeat (3) tick();
    en = 1'b1;
    tick();
    check("reen_an0", an_out, 4'hF);
    check("reen_fs", frame_start, 1'b1);
    tick();
    check("reen_an1", an_out, 4'hF);
    check("reen_fs_low", frame_start, 1'b0);
    tick();
    check("reen_an2", an_out, 4'hE);
    run_to(FRAME - 2);

    // Asynchronous reset between edges with staged data pending.
    run_to(4);
    pulse_load(28'($urandom), 4'($urandom));
    check("arst_pre_an", an_out, 4'hE);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_an", an_out, 4'hF);
    check("arst_seg", seg_out, 7'h7F);
    check("arst_dp", dp_out, 1'b1);
    check("arst_pending", pending, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_to(3);
    check("arst_after_an", an_out, 4'hE);
    check("arst_after_seg", seg_out, 7'h7F);
    repeat (FRAME + 3) tick();

    // Random traffic: sparse loads, occasional enable toggles.
    repeat (500) begin
      seg_in = 28'($urandom);
      dp_in  = 4'($urandom);
      load   = ($urandom_range(7) == 0);
      if ($urandom_range(39) == 0) en = ~en;
      tick();
    end
    load = 1'b0;
    en   = 1'b1;
    repeat (FRAME) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
